pe_array_acc: RTL and testbench
===============================

// Module: pe_array_acc
// PURPOSE
//  Parametrised PE array: NUM_PE signed fixed-point MAC lanes share one broadcast feature stream.
//  Per-lane bias + up to MAX_TAPS weights are preloaded; each window of conv_num features yields one
//  output vector (bias, round, ReLU, clamp). Sits between weight/feature buffers and output buffer.
// PARAMETERS
//  NUM_PE    64  number of MAC lanes (output channels)
//  DATA_W    16  feature/weight/bias/output width, signed two's complement
//  FRAC_W     8  fractional bits of the Q format (1 <= FRAC_W < DATA_W)
//  MAX_TAPS   9  per-lane weight storage depth (max taps per window)
//  ACC_W     40  accumulator width, >= 2*DATA_W + $clog2(MAX_TAPS)+1
// PORTS
//  clk            in   1               clock, all logic rising-edge
//  rst_pe         in   1               reset, synchronous, active-high
//  cfg_start      in   1               pulse: latch cfg, clear array, enter LOAD_W
//  conv_num       in   $clog2(MAX_TAPS+1) taps per window, sampled on cfg_start
//  relu_en        in   1               ReLU on output, sampled on cfg_start
//  partial_en     in   1               partial-sum mode, sampled on cfg_start
//  weight_valid   in   1               weight beat valid
//  weight_ready   out  1               weight beat accepted when valid&ready
//  input_weight_bias in NUM_PE*DATA_W  lane i at [(i+1)*DATA_W-1 : i*DATA_W]
//  feature_valid  in   1               feature beat valid
//  feature_ready  out  1               feature beat accepted when valid&ready
//  input_feature  in   DATA_W          feature broadcast to all lanes
//  out_valid      out  1               output vector valid, held until out_ready
//  out_ready      in   1               downstream accepts
//  output_feature out  NUM_PE*DATA_W   lane i result, same packing as weights
// BEHAVIOUR
//  Reset: state IDLE; weight_ready=feature_ready=out_valid=0; output_feature=0; accumulators,
//   tap counters, bias/weight regs cleared.
//  Config: conv_num 0 -> 1; conv_num > MAX_TAPS -> MAX_TAPS (N = effective taps).
//  FSM IDLE -> (cfg_start) LOAD_W -> MAC -> DRAIN -> OUT -> MAC ...
//   LOAD_W: weight_ready=1. Beat 0 = bias, beats 1..N = weights tap 0..N-1; after beat N -> MAC.
//   MAC: feature_ready=1. Beat k multiplies against weight[k]; after beat N-1 -> DRAIN (ready=0).
//   DRAIN: 2 cycles (product reg, then finalise reg). out_valid rises 2 cycles after last feature.
//   OUT: out_valid=1, output_feature stable until out_ready; on handshake -> MAC, tap=0, acc=0,
//    feature_ready high the next cycle. Weights retained across windows.
//  cfg_start in any state (incl. mid-window, OUT): has priority; accumulators, counters, out_valid
//   cleared next cycle, new cfg latched, -> LOAD_W. Pending output dropped.
//  Arithmetic per lane: prod = feature*weight (2*DATA_W signed), sign-extended to ACC_W, summed.
//   Finalise: if !partial_en add bias<<<FRAC_W; then y = (acc + 2^(FRAC_W-1)) >>> FRAC_W (round half up).
//   ReLU (relu_en & !partial_en): y<0 -> 0. partial_en: no bias, no ReLU.
//  ACC_W overflow not checked (ACC_W sized so it cannot occur).
// CONFIGURATION
//  PE_ARRAY_SAT_EN defined: y clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  PE_ARRAY_SAT_EN undefined: y truncated to low DATA_W bits (wraps).
// TESTING
//  T1 reset mid-MAC: rst_pe=1 one cycle -> all outputs 0, state IDLE; feature_valid ignored.
//  T2 N=1, FRAC_W=8, bias=1.0(0x0100), w=2.0(0x0200), f=1.5(0x0180), relu_en=0
//     -> all lanes 0x0400 (4.0); out_valid 2 cycles after feature accept.
//  T3 N=9, all w=0x0100, f=-1.0(0xFF00), bias=0, relu_en=1 -> 0x0000; relu_en=0 -> 0xF700 (-9.0).
//  T4 SAT: w=f=0x7FFF, N=9, bias=0x7FFF -> SAT_EN: 0x7FFF all lanes; without: low 16 bits of rounded sum.
//  T5 partial_en=1, bias=0x0500, N=2, w=0x0100, f=-1.0 -> 0xFE00 (bias/ReLU skipped, sign kept).
//  T6 out_ready=0 for 10 cycles -> out_valid/data stable, feature_ready=0; cfg_start then -> out_valid 0 next cycle, LOAD_W.

Source files
------------

// File: rtl/pe_array_acc.sv
// NUM_PE signed fixed-point MAC lanes sharing one broadcast feature stream; per-lane bias/weights,
// round-half-up, optional ReLU. Define PE_ARRAY_SAT_EN to clamp results instead of wrapping.
module pe_array_acc #(
  parameter int NUM_PE   = 64,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int MAX_TAPS = 9,
  parameter int ACC_W    = 40,
  parameter int CNT_W    = $clog2(MAX_TAPS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_pe,
  input  logic                       cfg_start,
  input  logic [CNT_W-1:0]           conv_num,
  input  logic                       relu_en,
  input  logic                       partial_en,
  input  logic                       weight_valid,
  output logic                       weight_ready,
  input  logic [NUM_PE*DATA_W-1:0]   input_weight_bias,
  input  logic                       feature_valid,
  output logic                       feature_ready,
  input  logic [DATA_W-1:0]          input_feature,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_PE*DATA_W-1:0]   output_feature
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_MAC    = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] TAP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TAP_MAX = CNT_W'(MAX_TAPS);
  localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           ntap_q;
  logic [CNT_W-1:0]           taps_eff_s;
  logic [CNT_W-1:0]           wsel_s;
  logic                       drain_q, drain_d;
  logic                       relu_q, part_q;
  logic                       weight_ready_q, feature_ready_q;
  logic                       prod_vld_q, out_valid_q;
  logic                       w_fire_s, f_fire_s, o_fire_s, fin_s;
  logic signed [DATA_W-1:0]   bias_q [NUM_PE];
  logic signed [DATA_W-1:0]   w_q    [NUM_PE][MAX_TAPS];
  logic signed [2*DATA_W-1:0] prod_q [NUM_PE];
  logic signed [ACC_W-1:0]    acc_q  [NUM_PE];
  logic [NUM_PE*DATA_W-1:0]   out_q;

  // Bias, round, optional ReLU, then clamp or wrap to DATA_W.
  function automatic logic [DATA_W-1:0] finalise(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [DATA_W-1:0] bias,
    input logic                     relu,
    input logic                     part
  );
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] r;
    logic [DATA_W-1:0]       res;
`ifdef PE_ARRAY_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] y;
`endif
    bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    if (part) begin
      r = acc + RND;
    end else begin
      r = acc + (bias_ext <<< FRAC_W) + RND;
    end
`ifdef PE_ARRAY_SAT_EN
    y = r >>> FRAC_W;
    if (relu && !part && (y < 0)) begin
      res = '0;
    end else if (y > MAXV) begin
      res = MAXV[DATA_W-1:0];
    end else if (y < MINV) begin
      res = MINV[DATA_W-1:0];
    end else begin
      res = y[DATA_W-1:0];
    end
`else
    if (relu && !part && (r < 0)) begin
      res = '0;
    end else begin
      res = DATA_W'(r >>> FRAC_W);
    end
`endif
    return res;
  endfunction

  assign w_fire_s = weight_valid & weight_ready_q;
  assign f_fire_s = feature_valid & feature_ready_q;
  assign o_fire_s = out_valid_q & out_ready;
  assign fin_s    = (state_q == S_DRAIN) & drain_q;
  assign wsel_s   = cnt_q - TAP_ONE;

  assign weight_ready   = weight_ready_q;
  assign feature_ready  = feature_ready_q;
  assign out_valid      = out_valid_q;
  assign output_feature = out_q;

  // Effective taps per window: 0 means 1, oversize saturates at MAX_TAPS.
  always_comb begin
    if (conv_num == '0) begin
      taps_eff_s = TAP_ONE;
    end else if (conv_num > TAP_MAX) begin
      taps_eff_s = TAP_MAX;
    end else begin
      taps_eff_s = conv_num;
    end
  end

  // Next-state logic; cfg_start preempts every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    if (cfg_start) begin
      state_d = S_LOAD_W;
      cnt_d   = '0;
      drain_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_LOAD_W: begin
          if (w_fire_s && (cnt_q == ntap_q)) begin
            state_d = S_MAC;
            cnt_d   = '0;
          end else if (w_fire_s) begin
            cnt_d = cnt_q + TAP_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_MAC: begin
          if (f_fire_s && (cnt_q == ntap_q - TAP_ONE)) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else if (f_fire_s) begin
            cnt_d = cnt_q + TAP_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            state_d = S_OUT;
            drain_d = 1'b0;
          end else begin
            drain_d = 1'b1;
          end
        end
        S_OUT: begin
          if (o_fire_s) begin
            state_d = S_MAC;
          end else begin
            state_d = S_OUT;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          drain_d = 1'b0;
        end
      endcase
    end
  end

  // State, counters, latched configuration and registered handshake readies.
  always_ff @(posedge clk) begin
    if (rst_pe) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      drain_q         <= 1'b0;
      ntap_q          <= '0;
      relu_q          <= 1'b0;
      part_q          <= 1'b0;
      weight_ready_q  <= 1'b0;
      feature_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      drain_q         <= drain_d;
      weight_ready_q  <= (state_d == S_LOAD_W);
      feature_ready_q <= (state_d == S_MAC);
      if (cfg_start) begin
        ntap_q <= taps_eff_s;
        relu_q <= relu_en;
        part_q <= partial_en;
      end
    end
  end

  // Per-lane storage, product pipeline, accumulation and output register.
  always_ff @(posedge clk) begin
    if (rst_pe) begin
      prod_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int l = 0; l < NUM_PE; l++) begin
        bias_q[l] <= '0;
        prod_q[l] <= '0;
        acc_q[l]  <= '0;
        for (int t = 0; t < MAX_TAPS; t++) begin
          w_q[l][t] <= '0;
        end
      end
    end else if (cfg_start) begin
      prod_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int l = 0; l < NUM_PE; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      prod_vld_q <= f_fire_s;
      for (int l = 0; l < NUM_PE; l++) begin
        if (w_fire_s && (cnt_q == '0)) begin
          bias_q[l] <= input_weight_bias[l*DATA_W +: DATA_W];
        end else if (w_fire_s) begin
          w_q[l][wsel_s] <= input_weight_bias[l*DATA_W +: DATA_W];
        end
        if (f_fire_s) begin
          prod_q[l] <= $signed(input_feature) * w_q[l][cnt_q];
        end
        // The handshake that releases OUT also starts the next window from zero.
        if (o_fire_s) begin
          acc_q[l] <= '0;
        end else if (prod_vld_q) begin
          acc_q[l] <= acc_q[l] + {{(ACC_W-2*DATA_W){prod_q[l][2*DATA_W-1]}}, prod_q[l]};
        end
        if (fin_s) begin
          out_q[l*DATA_W +: DATA_W] <= finalise(acc_q[l], bias_q[l], relu_q, part_q);
        end
      end
      if (fin_s) begin
        out_valid_q <= 1'b1;
      end else if (o_fire_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_acc.sv
// Randomised bench for pe_array_acc: an arithmetic reference model predicts every output vector,
// a negedge monitor compares the DUT against it, directed windows pin the model to literal values.
module tb_pe_array_acc;
  localparam int NUM_PE   = 64;
  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int MAX_TAPS = 9;
  localparam int ACC_W    = 40;
  localparam int CNT_W    = $clog2(MAX_TAPS + 1);
  typedef logic [NUM_PE*DATA_W-1:0] vec_t;

  logic clk, rst_pe, cfg_start, relu_en, partial_en;
  logic [CNT_W-1:0] conv_num;
  logic weight_valid, weight_ready, feature_valid, feature_ready, out_valid, out_ready;
  vec_t input_weight_bias, output_feature;
  logic [DATA_W-1:0] input_feature;

  pe_array_acc #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .MAX_TAPS(MAX_TAPS),
                 .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_pe(rst_pe), .cfg_start(cfg_start), .conv_num(conv_num),
    .relu_en(relu_en), .partial_en(partial_en), .weight_valid(weight_valid),
    .weight_ready(weight_ready), .input_weight_bias(input_weight_bias),
    .feature_valid(feature_valid), .feature_ready(feature_ready),
    .input_feature(input_feature), .out_valid(out_valid), .out_ready(out_ready),
    .output_feature(output_feature));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  vec_t exp_q[$];
  logic [DATA_W-1:0] m_bias[NUM_PE];
  logic [DATA_W-1:0] m_w[NUM_PE][MAX_TAPS];
  logic [DATA_W-1:0] feats[MAX_TAPS];
  int cur_n = 1;
  bit cur_relu, cur_part;
  int rdy_mode = 0;
  bit lat_arm = 1'b0;
  int lat_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  // Reference: y = round_half_up((sum f*w [+ bias*2^F]) / 2^F), then ReLU and clamp/wrap.
  function automatic vec_t model();
    vec_t r;
    longint s, y;
    longint lim_hi, lim_lo;
    r = '0;
    lim_hi = (longint'(1) << (DATA_W - 1)) - 1;
    lim_lo = -(longint'(1) << (DATA_W - 1));
    for (int l = 0; l < NUM_PE; l++) begin
      s = 0;
      for (int t = 0; t < cur_n; t++)
        s += longint'($signed(feats[t])) * longint'($signed(m_w[l][t]));
      if (!cur_part) s += longint'($signed(m_bias[l])) * (longint'(1) << FRAC_W);
      y = (s + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
      if (cur_relu && !cur_part && y < 0) y = 0;
`ifdef PE_ARRAY_SAT_EN
      if (y > lim_hi) y = lim_hi;
      if (y < lim_lo) y = lim_lo;
`else
      if (y > lim_hi + 1 || y < lim_lo - 1) s = 0;
`endif
      r[l*DATA_W +: DATA_W] = y[DATA_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rnd16();
    int v;
    if ($urandom_range(0, 1) == 0) begin
      v = int'($urandom);
    end else begin
      v = int'($urandom_range(0, 1024)) - 512;
    end
    return v[DATA_W-1:0];
  endfunction

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Compare process: output vector vs model queue, and out_valid latency after the last feature.
  always @(negedge clk) begin
    int bl;
    if (!rst_pe) begin
      if (lat_arm) begin
        if (out_valid) begin
          chk("out_latency", 64'(lat_cnt), 64'd2);
          lat_arm = 1'b0;
        end else if (lat_cnt >= 6) begin
          timeout("out_latency");
          lat_arm = 1'b0;
        end else begin
          lat_cnt++;
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          bl = 0;
          for (int l = NUM_PE - 1; l >= 0; l--)
            if (output_feature[l*DATA_W +: DATA_W] !== exp_q[0][l*DATA_W +: DATA_W]) bl = l;
          chk($sformatf("out_data_lane%0d", bl), 64'(output_feature[bl*DATA_W +: DATA_W]),
              64'(exp_q[0][bl*DATA_W +: DATA_W]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input int sel);
    bit ok;
    int b;
    ok = 1'b0;
    b = 0;
    while (!ok && b < 300) begin
      @(negedge clk);
      ok = (sel == 0) ? weight_ready : feature_ready;
      tick();
      b++;
    end
    if (!ok) timeout(sel == 0 ? "weight_handshake" : "feature_handshake");
  endtask

  task automatic do_cfg(input int cn, input bit relu, input bit part);
    cfg_start = 1'b1;
    conv_num = cn[CNT_W-1:0];
    relu_en = relu;
    partial_en = part;
    tick();
    cfg_start = 1'b0;
    exp_q.delete();
    lat_arm = 1'b0;
    cur_n = (cn == 0) ? 1 : (cn > MAX_TAPS) ? MAX_TAPS : cn;
    cur_relu = relu;
    cur_part = part;
  endtask

  task automatic set_weights(input bit rnd, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] w);
    for (int l = 0; l < NUM_PE; l++) begin
      m_bias[l] = rnd ? rnd16() : b;
      for (int t = 0; t < MAX_TAPS; t++) m_w[l][t] = rnd ? rnd16() : w;
    end
  endtask

  task automatic send_w(input vec_t v, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    weight_valid = 1'b1;
    input_weight_bias = v;
    handshake(0);
    weight_valid = 1'b0;
  endtask

  task automatic load(input bit gaps);
    vec_t v;
    for (int l = 0; l < NUM_PE; l++) v[l*DATA_W +: DATA_W] = m_bias[l];
    send_w(v, gaps);
    for (int t = 0; t < cur_n; t++) begin
      for (int l = 0; l < NUM_PE; l++) v[l*DATA_W +: DATA_W] = m_w[l][t];
      send_w(v, gaps);
    end
  endtask

  task automatic run_window(input bit rnd, input logic [DATA_W-1:0] fv, input bit gaps, input int nfeat);
    for (int k = 0; k < nfeat; k++) begin
      feats[k] = rnd ? rnd16() : fv;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      feature_valid = 1'b1;
      input_feature = feats[k];
      handshake(1);
      feature_valid = 1'b0;
    end
    if (nfeat == cur_n) begin
      exp_q.push_back(model());
      lat_cnt = 0;
      lat_arm = 1'b1;
    end
  endtask

  task automatic pin(input string name, input logic [DATA_W-1:0] lit);
    int b;
    chk({name, "_model"}, 64'(exp_q[0][DATA_W-1:0]), 64'(lit));
    b = 0;
    while (!out_valid && b < 20) begin
      tick();
      b++;
    end
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_lane0"}, 64'(output_feature[DATA_W-1:0]), 64'(lit));
    chk({name, "_lastlane"}, 64'(output_feature[NUM_PE*DATA_W-1 -: DATA_W]), 64'(lit));
  endtask

  task automatic drain_out();
    int b;
    rdy_mode = 2;
    b = 0;
    while (exp_q.size() > 0 && b < 200) begin
      tick();
      b++;
    end
    if (exp_q.size() > 0) timeout("drain_out");
  endtask

  task automatic directed(input int cn, input bit relu, input bit part, input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] f,
                          input string name, input logic [DATA_W-1:0] lit);
    rdy_mode = 0;
    do_cfg(cn, relu, part);
    set_weights(1'b0, b, w);
    load(1'b0);
    run_window(1'b0, f, 1'b0, cur_n);
    pin(name, lit);
    drain_out();
  endtask

  initial begin
    rst_pe = 1'b1; cfg_start = 1'b0; conv_num = '0; relu_en = 1'b0; partial_en = 1'b0;
    weight_valid = 1'b0; feature_valid = 1'b0; input_weight_bias = '0; input_feature = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_pe = 1'b0;
    @(negedge clk);
    chk("rst_weight_ready", 64'(weight_ready), 64'd0);
    chk("rst_feature_ready", 64'(feature_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_output_zero", 64'(output_feature == '0), 64'd1);
    tick();

    directed(1, 1'b0, 1'b0, 16'h0100, 16'h0200, 16'h0180, "t2_basic", 16'h0400);
    directed(9, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'hFF00, "t3_relu", 16'h0000);
    directed(9, 1'b0, 1'b0, 16'h0000, 16'h0100, 16'hFF00, "t3_norelu", 16'hF700);
`ifdef PE_ARRAY_SAT_EN
    directed(15, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, "t4_sat", 16'h7FFF);
`else
    directed(15, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, "t4_wrap", 16'h76FF);
`endif
    directed(2, 1'b1, 1'b1, 16'h0500, 16'h0100, 16'hFF00, "t5_partial", 16'hFE00);

    rdy_mode = 2;
    for (int c = 0; c < 5; c++) begin
      do_cfg(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_weights(1'b1, '0, '0);
      load(1'b1);
      for (int w = 0; w < 3; w++) run_window(1'b1, '0, 1'b1, cur_n);
      drain_out();
    end

    do_cfg(4, 1'b0, 1'b0);
    set_weights(1'b1, '0, '0);
    load(1'b1);
    run_window(1'b1, '0, 1'b1, 2);
    do_cfg(3, 1'b1, 1'b0);
    set_weights(1'b1, '0, '0);
    load(1'b1);
    for (int w = 0; w < 2; w++) run_window(1'b1, '0, 1'b1, cur_n);
    drain_out();

    rdy_mode = 0;
    do_cfg(3, 1'b0, 1'b0);
    set_weights(1'b1, '0, '0);
    load(1'b0);
    run_window(1'b1, '0, 1'b0, cur_n);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 64'(out_valid), 64'd1);
      chk("t6_hold_fready", 64'(feature_ready), 64'd0);
      tick();
    end
    do_cfg(2, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_cfg_drops_valid", 64'(out_valid), 64'd0);
    chk("t6_cfg_load_w", 64'(weight_ready), 64'd1);
    tick();

    rdy_mode = 2;
    do_cfg(9, 1'b0, 1'b0);
    set_weights(1'b1, '0, '0);
    load(1'b0);
    run_window(1'b1, '0, 1'b0, 3);
    feature_valid = 1'b1;
    input_feature = rnd16();
    rst_pe = 1'b1;
    tick();
    rst_pe = 1'b0;
    exp_q.delete();
    lat_arm = 1'b0;
    @(negedge clk);
    chk("t1_weight_ready", 64'(weight_ready), 64'd0);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_output_zero", 64'(output_feature == '0), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_feature_ignored", 64'(feature_ready), 64'd0);
      tick();
    end
    feature_valid = 1'b0;

    do_cfg(0, 1'b1, 1'b0);
    set_weights(1'b1, '0, '0);
    load(1'b1);
    for (int w = 0; w < 3; w++) run_window(1'b1, '0, 1'b1, cur_n);
    drain_out();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
